// File: rtl/cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// cpu_mem_responder
//   Memory-side responder for the CPU memory port. Provides a unified
//   instruction/data RAM, a memory-mapped 8N1 UART transmitter fed by a TX
//   FIFO, and a free-running cycle counter. Reads are combinational; writes
//   commit on the rising edge of clk.
//
//   Address map (full 32-bit decode):
//     0x0000_0000 .. RAM_WORDS*4-1 : RAM
//     0x8000_0000 UART_DATA   (W: enqueue byte, R: 0)
//     0x8000_0004 UART_STATUS (R: {count,ovf,busy,empty,full}, W: clear ovf)
//     0x8000_0008 CYCLE       (R)
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   mem_addr     byte address from the CPU
//   mem_wdata    write data, byte-lane-0 aligned
//   mem_wenable  byte write enables, lane-0 aligned (0000 = read)
//   mem_rdata    combinational read data, shifted down by the byte offset
//   uart_tx      registered serial output, idle high
// -----------------------------------------------------------------------------
module cpu_mem_responder #(
  parameter int    RAM_WORDS  = 1024,
  parameter string INIT_FILE  = "",
  parameter int    CLK_DIV    = 868,
  parameter int    FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wenable,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);

  localparam int IDX_W   = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int PTR_W   = FIFO_AW + 1;
  localparam int BAUD_W  = $clog2(CLK_DIV);

  localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS * 4);
  localparam logic [29:0] WA_DATA    = 30'h2000_0000;
  localparam logic [29:0] WA_STATUS  = 30'h2000_0001;
  localparam logic [29:0] WA_CYCLE   = 30'h2000_0002;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  // ---------------------------------------------------------------------------
  // Decode and lane alignment
  // ---------------------------------------------------------------------------
  logic [1:0]       w_off;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic             w_is_ram, w_is_data, w_is_status, w_is_cycle;
  logic [IDX_W-1:0] w_ram_idx;

  assign w_off       = mem_addr[1:0];
  // Enables shifted past lane 3 fall off the top of the 4-bit result.
  assign w_be        = mem_wenable << w_off;
  assign w_wdata     = mem_wdata << {w_off, 3'b000};
  assign w_is_ram    = (mem_addr < RAM_BYTES);
  assign w_is_data   = (mem_addr[31:2] == WA_DATA);
  assign w_is_status = (mem_addr[31:2] == WA_STATUS);
  assign w_is_cycle  = (mem_addr[31:2] == WA_CYCLE);
  assign w_ram_idx   = mem_addr[IDX_W+1:2];

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic [31:0] r_ram [RAM_WORDS];

  // NOTE: storage arrays have no reset; contents survive rst_n and map to plain RAM.
  always_ff @(posedge clk) begin
    if (w_is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_ram[w_ram_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------------
  logic [31:0] r_cycle;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cycle <= '0;
    else        r_cycle <= r_cycle + 32'd1;
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr, w_count;
  logic             w_full, w_empty, w_push_req, w_push, w_pop;
  logic             r_overflow;
  logic [7:0]       w_head;

  assign w_count    = r_wptr - r_rptr;
  assign w_full     = (w_count == PTR_W'(FIFO_DEPTH));
  assign w_empty    = (r_wptr == r_rptr);
  assign w_head     = r_fifo[r_rptr[FIFO_AW-1:0]];
  assign w_push_req = w_is_data & w_be[0];
  // Fullness is judged before the edge, so a same-edge pop cannot rescue the byte.
  assign w_push     = w_push_req & ~w_full;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[FIFO_AW-1:0]] <= w_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_push_req && w_full)          r_overflow <= 1'b1;
      else if (w_is_status && w_be[0])   r_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  tx_state_e         r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shreg;
  logic              r_tx;
  logic              w_baud_done;

  assign w_baud_done = (r_baud == BAUD_LAST);
  // A byte is taken from idle, or at the end of a stop bit for back-to-back frames.
  assign w_pop = ~w_empty &
                 ((r_state == S_IDLE) | ((r_state == S_STOP) & w_baud_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
      r_rptr  <= '0;
    end else begin
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_shreg <= w_head;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_baud  <= '0;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shreg[0];
            r_shreg <= r_shreg >> 1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shreg[0];
              r_shreg <= r_shreg >> 1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (!w_empty) begin
              r_shreg <= w_head;
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_tx = r_tx;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [3:0]  w_cnt_disp;
  logic [31:0] w_status, w_word;

  always_comb begin
    w_cnt_disp = 4'(w_count);
    if (32'(w_count) > 32'd15) w_cnt_disp = 4'hF;
  end

  assign w_status = {20'b0, w_cnt_disp, 4'b0, r_overflow,
                     (r_state != S_IDLE), w_empty, w_full};

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_word = '0;
    if (w_is_ram)         w_word = r_ram[w_ram_idx];
    else if (w_is_status) w_word = w_status;
    else if (w_is_cycle)  w_word = r_cycle;
  end

  assign mem_rdata = w_word >> {w_off, 3'b000};

endmodule

// File: tb/tb_cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_cpu_mem_responder
//   Directed and randomized checks of cpu_mem_responder. RAM behaviour is
//   compared with a byte-addressed memory model; UART output is recorded per
//   cycle and decoded back into bytes; exact frame timing is compared with a
//   bit pattern built from the 8N1 framing rules.
// -----------------------------------------------------------------------------
module tb_cpu_mem_responder;

  localparam int RAM_WORDS  = 256;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 10 * CLK_DIV;

  localparam logic [31:0] A_DATA = 32'h8000_0000;
  localparam logic [31:0] A_STAT = 32'h8000_0004;
  localparam logic [31:0] A_CYC  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wenable = '0;
  logic [31:0] mem_rdata;
  logic        uart_tx;

  int checks   = 0;
  int failures = 0;

  byte unsigned mbytes [RAM_WORDS*4];

  logic rec = 1'b0;
  logic tx_log [$];

  cpu_mem_responder #(
    .RAM_WORDS (RAM_WORDS),
    .INIT_FILE (""),
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wenable(mem_wenable),
    .mem_rdata  (mem_rdata),
    .uart_tx    (uart_tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rec) tx_log.push_back(uart_tx);

  initial begin
    #500_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
    @(negedge clk);
    mem_addr    = addr;
    mem_wdata   = data;
    mem_wenable = be;
    @(posedge clk);
    #1;
    mem_wenable = '0;
  endtask

  task automatic mem_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    mem_addr    = addr;
    mem_wenable = '0;
    #1;
    data = mem_rdata;
  endtask

  // Byte-addressed reference: lane i of the CPU data lands at addr+i if it stays in the word.
  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] be);
    int off  = int'(addr[1:0]);
    int base = int'(addr) - off;
    for (int i = 0; i < 4; i++)
      if (be[i] && (off + i) < 4) mbytes[base + off + i] = data[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int off  = int'(addr[1:0]);
    int base = int'(addr) - off;
    logic [31:0] r = '0;
    for (int i = 0; i < 4 - off; i++) r[8*i +: 8] = mbytes[base + off + i];
    return r;
  endfunction

  function automatic logic sample(input int idx);
    if (idx < 0 || idx >= tx_log.size()) return 1'bx;
    return tx_log[idx];
  endfunction

  // Waits for enough recorded line samples, then decodes back-to-back 8N1 frames.
  task automatic check_line(input string tag, input logic [7:0] exp_q [$]);
    int need  = FRAME * exp_q.size() + 50;
    int guard = 0;
    int s     = -1;
    while (tx_log.size() < need && guard < need * 4) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " samples"}, 32'(tx_log.size() >= need), 32'd1);
    for (int i = 0; i < tx_log.size(); i++)
      if (tx_log[i] == 1'b0 && s < 0) s = i;
    check({tag, " start found"}, 32'(s >= 0), 32'd1);
    if (s >= 0) begin
      for (int k = 0; k < exp_q.size(); k++) begin
        logic [7:0] got;
        int fb = s + FRAME * k;
        for (int j = 0; j < 8; j++) got[j] = sample(fb + CLK_DIV * (j + 1) + CLK_DIV / 2);
        check($sformatf("%s frame%0d start", tag, k), 32'(sample(fb + CLK_DIV / 2)), 32'd0);
        check($sformatf("%s frame%0d byte", tag, k), 32'(got), 32'(exp_q[k]));
        check($sformatf("%s frame%0d stop", tag, k), 32'(sample(fb + 9 * CLK_DIV + CLK_DIV / 2)), 32'd1);
      end
    end
  endtask

  initial begin
    logic [31:0] rd, c0, c1;
    logic [7:0]  q [$];
    logic [7:0]  b55;

    // ---------------- reset state ----------------
    #12;
    check("reset uart_tx", 32'(uart_tx), 32'd1);
    mem_addr = A_STAT; #1;
    check("reset status", mem_rdata, 32'h0000_0002);
    mem_addr = A_CYC; #1;
    check("reset cycle", mem_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- word / byte / halfword ----------------
    mem_write(32'h10, 32'hDEAD_BEEF, 4'b1111); model_write(32'h10, 32'hDEAD_BEEF, 4'b1111);
    mem_read(32'h10, rd); check("word rd 0x10", rd, 32'hDEAD_BEEF);
    mem_read(32'h11, rd); check("word rd 0x11", rd, 32'h00DE_ADBE);
    mem_read(32'h13, rd); check("word rd 0x13", rd, 32'h0000_00DE);
    mem_write(32'h12, 32'h0000_00AA, 4'b0001); model_write(32'h12, 32'h0000_00AA, 4'b0001);
    mem_read(32'h10, rd); check("byte wr 0x12", rd, 32'hDEAA_BEEF);
    mem_write(32'h13, 32'h0000_1234, 4'b0011); model_write(32'h13, 32'h0000_1234, 4'b0011);
    mem_read(32'h10, rd); check("half wr 0x13", rd, 32'h34AA_BEEF);
    mem_read(32'h12, rd); check("half rd 0x12", rd, model_read(32'h12));

    // ---------------- map boundaries ----------------
    mem_write(RAM_WORDS*4 - 4, 32'hA5C3_0F71, 4'b1111);
    mem_read(RAM_WORDS*4 - 4, rd); check("last ram word", rd, 32'hA5C3_0F71);
    mem_read(RAM_WORDS*4, rd);     check("past ram end", rd, 32'd0);
    mem_read(32'h4000_0000, rd);   check("unmapped rd", rd, 32'd0);
    mem_read(A_DATA, rd);          check("uart_data rd", rd, 32'd0);

    // ---------------- randomized RAM traffic ----------------
    for (int w = 32; w < 96; w++) begin
      logic [31:0] d = $urandom;
      mem_write(32'(w * 4), d, 4'b1111);
      model_write(32'(w * 4), d, 4'b1111);
    end
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a = 32'($urandom_range(32 * 4, 96 * 4 - 1));
      logic [31:0] d = $urandom;
      logic [3:0]  be = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        mem_write(a, d, be);
        model_write(a, d, be);
      end else begin
        mem_read(a, rd);
        check($sformatf("rand rd %h", a), rd, model_read(a));
      end
    end

    // ---------------- CYCLE ----------------
    mem_read(A_CYC, c0);
    repeat (99) @(negedge clk);
    mem_read(A_CYC, c1);
    check("cycle delta 100", c1 - c0, 32'd100);
    mem_read(A_CYC, c0);
    mem_write(A_CYC, 32'h0000_0000, 4'b1111);
    mem_read(A_CYC, c1);
    check("cycle write ignored", c1 - c0, 32'd2);

    // ---------------- exact UART frame timing ----------------
    b55 = 8'h55;
    mem_write(A_DATA, 32'h0000_0055, 4'b0001);
    mem_addr = A_STAT; #1;
    check("busy before start", 32'(mem_rdata[2]), 32'd0);
    @(posedge clk);
    for (int i = 0; i < FRAME; i++) begin
      logic exp_bit;
      @(negedge clk);
      if (i < CLK_DIV)              exp_bit = 1'b0;
      else if (i < 9 * CLK_DIV)     exp_bit = b55[(i - CLK_DIV) / CLK_DIV];
      else                          exp_bit = 1'b1;
      check($sformatf("frame55 tx cyc%0d", i), 32'(uart_tx), 32'(exp_bit));
      check($sformatf("frame55 busy cyc%0d", i), 32'(mem_rdata[2]), 32'd1);
    end
    @(negedge clk);
    check("frame55 idle tx", 32'(uart_tx), 32'd1);
    check("frame55 status after", mem_rdata, 32'h0000_0002);

    // ---------------- overflow ----------------
    tx_log.delete();
    rec = 1'b1;
    for (int b = 1; b <= 6; b++) mem_write(A_DATA, 32'(b), 4'b0001);
    mem_read(A_STAT, rd);
    check("overflow status", rd, 32'h0000_040D);
    mem_write(A_STAT, 32'h0000_0000, 4'b0001);
    mem_read(A_STAT, rd);
    check("overflow cleared", rd, 32'h0000_0405);
    q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    check_line("ovf line", q);
    rec = 1'b0;

    // ---------------- random bytes on the line ----------------
    repeat (FRAME) @(negedge clk);
    tx_log.delete();
    q.delete();
    rec = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] v = 8'($urandom);
      q.push_back(v);
      mem_write(A_DATA, 32'($urandom) & 32'hFFFF_FF00 | 32'(v), 4'b0001);
    end
    check_line("rand line", q);
    rec = 1'b0;

    // ---------------- reset mid-frame ----------------
    repeat (FRAME) @(negedge clk);
    mem_write(A_DATA, 32'h0000_0000, 4'b0001);
    repeat (12) @(negedge clk);
    check("midframe tx low", 32'(uart_tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset tx", 32'(uart_tx), 32'd1);
    mem_addr = A_STAT; #1;
    check("in-reset status", mem_rdata, 32'h0000_0002);
    mem_addr = A_CYC; #1;
    check("in-reset cycle", mem_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_read(A_STAT, rd); check("post-reset status", rd, 32'h0000_0002);
    mem_read(A_CYC, rd);  check("post-reset cycle", rd, 32'd2);
    mem_read(32'h10, rd); check("ram kept over reset", rd, 32'h34AA_BEEF);
    check("post-reset tx idle", 32'(uart_tx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
